// File: rtl/p_div_pkg.sv
// p_div_pkg: pack-width decode, lane helpers and FSM encoding for the packed divider
package p_div_pkg;
  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8 = 2;
  localparam int PW_4 = 3;
  localparam int PW_2 = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic logic [4:0] pw_last(input logic [4:0] pw);
    return (pw[PW_32] || pw == 5'd0) ? 5'd31 : pw[PW_16] ? 5'd15 : pw[PW_8] ? 5'd7 :
           pw[PW_4] ? 5'd3 : 5'd1;
  endfunction
  function automatic logic [31:0] pw_lsb(input logic [4:0] pw);
    return (pw[PW_32] || pw == 5'd0) ? 32'h0000_0001 : pw[PW_16] ? 32'h0001_0001 :
           pw[PW_8] ? 32'h0101_0101 : pw[PW_4] ? 32'h1111_1111 : 32'h5555_5555;
  endfunction
  function automatic logic [31:0] lane_fill(input logic [31:0] v, input logic [31:0] lsb);
    logic [31:0] m;
    m[31] = v[31];
    for (int i = 30; i >= 0; i--) m[i] = lsb[i+1] ? v[i] : m[i+1];
    return m;
  endfunction
endpackage

// File: rtl/p_div_sub.sv
// p_div_sub: 32-bit packed subtractor with lane-broken borrow chain and lane borrow mask
module p_div_sub
  import p_div_pkg::*;
(
  input  logic [4:0]  pw,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic [31:0] borrow
);
  logic [31:0] lsb;
  logic [31:0] bo;
  logic c;
  logic ci;
  assign lsb = pw_lsb(pw);
  always_comb begin
    diff = '0;
    bo = '0;
    c = 1'b0;
    ci = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ci = lsb[i] ? 1'b0 : c;
      diff[i] = a[i] ^ b[i] ^ ci;
      c = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & ci);
      bo[i] = c;
    end
    borrow = lane_fill(bo, lsb);
  end
endmodule

// File: rtl/p_div.sv
// p_div: multi-cycle packed unsigned restoring divider returning quotient or remainder lanes
module p_div
  import p_div_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic        div_q,
  input  logic        div_r,
  input  logic [4:0]  pw,
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
  output logic [31:0] result
);
  logic [1:0] state;
  logic [4:0] count;
  logic [4:0] pw_r;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dv;
  logic [31:0] lsb;
  logic [31:0] msb;
  logic [31:0] rem_sh;
  logic [31:0] diff;
  logic [31:0] borrow;
  logic [31:0] take;
  assign lsb = pw_lsb(pw_r);
  assign msb = {1'b1, lsb[31:1]};
  assign rem_sh = ((rem << 1) & ~lsb) | (lane_fill(quo & msb, lsb) & lsb);
  assign take = ~borrow | lane_fill(rem & msb, lsb);
  assign ready = state == S_DONE;
  assign result = div_q ? quo : div_r ? rem : '0;
  p_div_sub u_sub (
    .pw(pw_r),
    .a(rem_sh),
    .b(dv),
    .diff(diff),
    .borrow(borrow)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      pw_r <= '0;
      quo <= '0;
      rem <= '0;
      dv <= '0;
    end else if (state == S_IDLE) begin
      if (valid) begin
        state <= S_RUN;
        count <= pw_last(pw);
        pw_r <= pw;
        quo <= crs1;
        rem <= '0;
        dv <= crs2;
      end
    end else if (state == S_RUN) begin
      if (!valid) begin
        state <= S_IDLE;
      end else begin
        state <= count == 5'd0 ? S_DONE : S_RUN;
        count <= count - 5'(|count);
        rem <= (diff & take) | (rem_sh & ~take);
        quo <= ((quo << 1) & ~lsb) | (take & lsb);
      end
    end else begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_p_div.sv
// tb_p_div: directed and randomized checks of p_div against a lane-wise arithmetic model
module tb_p_div;
  logic clock = 1'b0;
  logic reset;
  logic valid;
  logic ready;
  logic div_q;
  logic div_r;
  logic [4:0] pw;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [31:0] result;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clock = ~clock;
  p_div dut (
    .clock(clock),
    .reset(reset),
    .valid(valid),
    .ready(ready),
    .div_q(div_q),
    .div_r(div_r),
    .pw(pw),
    .crs1(crs1),
    .crs2(crs2),
    .result(result)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic int wid(input logic [4:0] p);
    if (p[0] || p == 5'd0) return 32;
    if (p[1]) return 16;
    if (p[2]) return 8;
    if (p[3]) return 4;
    return 2;
  endfunction
  function automatic void model(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    int w;
    longint unsigned m, x, y, qq, rr;
    w = wid(p);
    m = (64'd1 << w) - 64'd1;
    q = '0;
    r = '0;
    for (int k = 0; k < 32 / w; k++) begin
      x = (64'(a) >> (k * w)) & m;
      y = (64'(b) >> (k * w)) & m;
      if (y == 0) begin
        qq = m;
        rr = x;
      end else begin
        qq = x / y;
        rr = x % y;
      end
      q |= 32'(qq << (k * w));
      r |= 32'(rr << (k * w));
    end
  endfunction
  task automatic run_req(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] qe, input logic [31:0] re, input string tag);
    int n;
    @(negedge clock);
    pw = p;
    crs1 = a;
    crs2 = b;
    valid = 1'b1;
    div_q = 1'b1;
    div_r = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (ready) break;
    end
    check({tag, " latency"}, n, wid(p) + 1);
    if (ready) begin
      check({tag, " quo"}, result, qe);
      div_q = 1'b0;
      div_r = 1'b1;
      #1 check({tag, " rem"}, result, re);
      div_r = 1'b0;
      #1 check({tag, " none"}, result, 32'd0);
      div_q = 1'b1;
      div_r = 1'b1;
      #1 check({tag, " both"}, result, qe);
    end
    valid = 1'b0;
    div_q = 1'b0;
    div_r = 1'b0;
    @(posedge clock);
    #1 check({tag, " pulse"}, ready, 1'b0);
  endtask
  initial begin
    logic [31:0] q, r, a, b;
    logic [4:0] p;
    int seen;
    reset = 1'b1;
    valid = 1'b0;
    div_q = 1'b1;
    div_r = 1'b0;
    pw = 5'd1;
    crs1 = '0;
    crs2 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset ready", ready, 1'b0);
    check("reset result", result, 32'd0);
    reset = 1'b0;
    run_req(5'b00001, 32'd100, 32'd7, 32'd14, 32'd2, "pw32");
    run_req(5'b00010, 32'h0064_0009, 32'h0007_0002, 32'h000E_0004, 32'h0002_0001, "pw16");
    run_req(5'b00100, 32'h1234_5678, 32'h00FF_0001, 32'hFF00_FF78, 32'h1234_5600, "pw8 dz");
    run_req(5'b10000, 32'hFFFF_FFFF, 32'h5555_5555, 32'hFFFF_FFFF, 32'h0, "pw2");
    run_req(5'b01000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_1111, 32'h0, "pw4");
    run_req(5'b00000, 32'd100, 32'd7, 32'd14, 32'd2, "pw zero");
    run_req(5'b00110, 32'h0064_0009, 32'h0007_0002, 32'h000E_0004, 32'h0002_0001, "pw multi");
    @(negedge clock);
    pw = 5'b00001;
    crs1 = 32'd1000;
    crs2 = 32'd3;
    valid = 1'b1;
    @(posedge clock);
    repeat (5) @(posedge clock);
    @(negedge clock);
    valid = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (ready) seen++;
    end
    check("abort no ready", seen, 0);
    run_req(5'b00001, 32'd1000, 32'd3, 32'd333, 32'd1, "after abort");
    @(negedge clock);
    pw = 5'b00001;
    crs1 = 32'hDEAD_BEEF;
    crs2 = 32'd5;
    valid = 1'b1;
    div_q = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 check("reset ready mid", ready, 1'b0);
    check("reset result mid", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    valid = 1'b0;
    div_q = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      p = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(5'd1 << $urandom_range(0, 4));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b &= $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      model(p, a, b, q, r);
      run_req(p, a, b, q, r, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
